// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-granular arbiter that shares one UART transmitter between several
// byte-stream requesters, with a stall timeout that reclaims a silent grant holder.
module uart_tx_arbiter #(
  parameter int N_REQ   = 3,
  parameter int TIMEOUT = 1_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_data,
  input  logic [N_REQ-1:0]   req_last,
  output logic [N_REQ-1:0]   req_ready,
  input  logic               tx_busy,
  input  logic               tx_done,
  output logic               tx_start,
  output logic [7:0]         tx_data,
  output logic               grant_valid,
  output logic [2:0]         grant_id,
  output logic               timeout_flag
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TimerMax = TW'(TIMEOUT - 1);
  localparam logic [2:0]    RrInit   = 3'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StLoad, StWaitDone} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    rr_q, rr_d;
  logic [2:0]    grant_id_q, grant_id_d;
  logic          grant_valid_q, grant_valid_d;
  logic          last_q, last_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          timeout_q, timeout_d;

  logic          arb_found;
  logic [2:0]    arb_idx;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;

  // Two passes give a wrapping search starting just above the last holder.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (!arb_found && req_valid[i] && (3'(i) > rr_q)) begin
        arb_found = 1'b1;
        arb_idx   = 3'(i);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!arb_found && req_valid[i] && (3'(i) <= rr_q)) begin
        arb_found = 1'b1;
        arb_idx   = 3'(i);
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant_id_q == 3'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_ready[i] = (state_q == StLoad) && grant_valid_q && (grant_id_q == 3'(i)) && !tx_busy;
    end
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    rr_d          = rr_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    last_d        = last_q;
    tx_data_d     = tx_data_q;
    tx_start_d    = 1'b0;
    timeout_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (arb_found) begin
          grant_id_d    = arb_idx;
          grant_valid_d = 1'b1;
          timer_d       = '0;
          state_d       = StLoad;
        end
      end
      StLoad: begin
        // A foreign frame still shifting freezes both the handshake and the stall timer.
        if (!tx_busy) begin
          if (sel_valid) begin
            tx_data_d  = sel_data;
            last_d     = sel_last;
            tx_start_d = 1'b1;
            state_d    = StWaitDone;
          end else if (timer_q == TimerMax) begin
            grant_valid_d = 1'b0;
            timeout_d     = 1'b1;
            rr_d          = grant_id_q;
            state_d       = StIdle;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      StWaitDone: begin
        if (tx_done) begin
          if (last_q) begin
            grant_valid_d = 1'b0;
            rr_d          = grant_id_q;
            state_d       = StIdle;
          end else begin
            timer_d = '0;
            state_d = StLoad;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      timer_q       <= '0;
      rr_q          <= RrInit;
      grant_id_q    <= '0;
      grant_valid_q <= 1'b0;
      last_q        <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_data_q     <= '0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      rr_q          <= rr_d;
      grant_id_q    <= grant_id_d;
      grant_valid_q <= grant_valid_d;
      last_q        <= last_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      timeout_q     <= timeout_d;
    end
  end

  assign tx_start     = tx_start_q;
  assign tx_data      = tx_data_q;
  assign grant_valid  = grant_valid_q;
  assign grant_id     = grant_id_q;
  assign timeout_flag = timeout_q;

  a_start_single: assert property (@(posedge clk) disable iff (rst) tx_start_q |=> !tx_start_q);
  a_ready_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
  a_grant_range:  assert property (@(posedge clk) disable iff (rst)
                                   grant_valid_q |-> (32'(grant_id_q) < 32'(N_REQ)));

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomised bench for uart_tx_arbiter: requester/uart_tx models, a transaction-level
// reference of the arbitration rules and a byte scoreboard, plus directed scenarios.
module tb_uart_tx_arbiter;

  localparam int N  = 3;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data  = '0;
  logic [N-1:0]   req_last  = '0;
  logic [N-1:0]   req_ready;
  logic           tx_busy = 1'b0;
  logic           tx_done = 1'b0;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           grant_valid;
  logic [2:0]     grant_id;
  logic           timeout_flag;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .N_REQ  (N),
    .TIMEOUT(TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_busy     (tx_busy),
    .tx_done     (tx_done),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout_flag(timeout_flag)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Requester scripts: {stall, 6'b0, last, data}; a stall entry holds valid low for data cycles.
  logic [15:0] gq [N][$];
  int          wait_cnt [N];
  logic [7:0]  sb [$];
  int          hist [$];
  int          n_start = 0;
  int          n_tmo   = 0;
  bit          gv_prev = 1'b0;
  bit          saw_start = 1'b0;
  logic [N-1:0] fire_q = '0;
  bit          rst_req = 1'b1;
  bit          foreign_req = 1'b0;
  int          foreign_len = 20;
  int          uart_len = 5;
  int          ubusy_cnt = 0;

  // Reference view of the arbiter: who holds the line, whether its byte is on the wire,
  // how long it has been silent, and the last registered outputs.
  int          m_holder = -1;
  int          m_id = 0;
  int          m_rr = N - 1;
  bit          m_inflight = 1'b0;
  bit          m_last = 1'b0;
  int          m_quiet = 0;
  bit          m_start = 1'b0;
  logic [7:0]  m_data = '0;
  bit          m_tmo = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] v, input int after);
    int c;
    for (int k = 1; k <= N; k++) begin
      c = (after + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  task automatic model_step();
    int w;
    bit s;
    bit t;
    s = 1'b0;
    t = 1'b0;
    if (rst) begin
      m_holder = -1; m_id = 0; m_rr = N - 1; m_inflight = 1'b0; m_last = 1'b0;
      m_quiet = 0; m_data = '0;
      sb.delete();
    end else if (m_holder < 0) begin
      w = rr_pick(req_valid, m_rr);
      if (w >= 0) begin
        m_holder = w; m_id = w; m_quiet = 0;
      end
    end else if (m_inflight) begin
      if (tx_done) begin
        m_inflight = 1'b0;
        if (m_last) begin
          m_rr = m_id; m_holder = -1;
        end else begin
          m_quiet = 0;
        end
      end
    end else if (!tx_busy) begin
      if (req_valid[m_holder]) begin
        m_data = req_data[8*m_holder +: 8];
        m_last = req_last[m_holder];
        m_inflight = 1'b1;
        s = 1'b1;
      end else if (m_quiet == TO - 1) begin
        t = 1'b1; m_rr = m_id; m_holder = -1;
      end else begin
        m_quiet++;
      end
    end
    m_start = s;
    m_tmo = t;
  endtask

  initial begin
    logic [N-1:0] exp_ready;
    logic [15:0]  e;
    forever begin
      @(negedge clk);
      exp_ready = '0;
      if (m_holder >= 0 && !m_inflight && !tx_busy) exp_ready[m_holder] = 1'b1;
      check_eq("req_ready", 32'(req_ready), 32'(exp_ready));
      check_eq("tx_start", 32'(tx_start), 32'(m_start));
      check_eq("tx_data", 32'(tx_data), 32'(m_data));
      check_eq("grant_valid", 32'(grant_valid), 32'(m_holder >= 0));
      check_eq("grant_id", 32'(grant_id), 32'(m_id));
      check_eq("timeout_flag", 32'(timeout_flag), 32'(m_tmo));
      if (tx_start) begin
        n_start++;
        check_eq("sb_has_byte", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) check_eq("sb_byte", 32'(tx_data), 32'(sb.pop_front()));
      end
      if (timeout_flag) n_tmo++;
      if (grant_valid && !gv_prev) hist.push_back(int'(grant_id));
      gv_prev   = grant_valid;
      saw_start = tx_start;
      fire_q    = rst ? '0 : (req_valid & req_ready);
      for (int i = 0; i < N; i++) if (fire_q[i]) sb.push_back(req_data[8*i +: 8]);
      model_step();

      @(posedge clk);
      #1;
      rst = rst_req;
      rst_req = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (rst) begin
          gq[i].delete();
          wait_cnt[i] = 0;
          req_valid[i] = 1'b0;
          req_last[i] = 1'b0;
        end else begin
          if (fire_q[i]) req_valid[i] = 1'b0;
          if (!req_valid[i]) begin
            if (wait_cnt[i] > 0) begin
              wait_cnt[i]--;
            end else if (gq[i].size() != 0) begin
              e = gq[i].pop_front();
              if (e[15]) begin
                wait_cnt[i] = int'(e[7:0]);
              end else begin
                req_valid[i] = 1'b1;
                req_last[i] = e[8];
                req_data[8*i +: 8] = e[7:0];
              end
            end
          end
        end
      end
      tx_done = 1'b0;
      if (ubusy_cnt > 0) begin
        ubusy_cnt--;
        if (ubusy_cnt == 0) begin
          tx_busy = 1'b0;
          tx_done = 1'b1;
        end
      end else if (saw_start) begin
        tx_busy = 1'b1;
        ubusy_cnt = uart_len;
      end else if (foreign_req && !gv_prev) begin
        tx_busy = 1'b1;
        ubusy_cnt = foreign_len;
        foreign_req = 1'b0;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #3;
  endtask

  task automatic push_byte(input int r, input logic [7:0] d, input logic last);
    gq[r].push_back({7'b0, last, d});
  endtask

  task automatic push_stall(input int r, input int n);
    gq[r].push_back({1'b1, 7'b0, 8'(n)});
  endtask

  task automatic push_pkt(input int r, input int len);
    for (int b = 0; b < len; b++) push_byte(r, 8'($urandom), b == len - 1);
  endtask

  task automatic push_rand_pkt(input int r);
    int len;
    int p;
    len = $urandom_range(1, 4);
    if ($urandom_range(0, 3) == 0) push_stall(r, $urandom_range(1, 6));
    for (int b = 0; b < len; b++) begin
      p = $urandom_range(0, 11);
      if (b > 0 && p == 0) push_stall(r, $urandom_range(18, 30));
      else if (b > 0 && p < 3) push_stall(r, $urandom_range(1, 5));
      push_byte(r, 8'($urandom), b == len - 1);
    end
  endtask

  function automatic bit is_idle();
    bit idle;
    idle = (req_valid == '0) && (m_holder < 0) && (ubusy_cnt == 0) && !foreign_req;
    for (int i = 0; i < N; i++) if (gq[i].size() != 0 || wait_cnt[i] != 0) idle = 1'b0;
    return idle;
  endfunction

  task automatic drain(input string tag, input int budget);
    int k;
    k = 0;
    while (!is_idle() && k < budget) begin
      cyc(1);
      k++;
    end
    check_eq(tag, 32'(is_idle()), 32'd1);
    cyc(2);
  endtask

  initial begin
    int s0;
    int t0;
    int k;

    cyc(3);
    check_eq("rst_grant_valid", 32'(grant_valid), 32'd0);
    check_eq("rst_grant_id", 32'(grant_id), 32'd0);
    check_eq("rst_tx_start", 32'(tx_start), 32'd0);
    check_eq("rst_timeout", 32'(timeout_flag), 32'd0);
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);

    // Single three-byte packet from requester 1.
    uart_len = 5; hist.delete(); s0 = n_start;
    push_byte(1, 8'h41, 1'b0); push_byte(1, 8'h42, 1'b0); push_byte(1, 8'h43, 1'b1);
    drain("p1_drain", 400);
    check_eq("p1_starts", 32'(n_start - s0), 32'd3);
    check_eq("p1_grants", 32'(hist.size()), 32'd1);
    check_eq("p1_grant_id", 32'(hist[0]), 32'd1);
    check_eq("p1_last_byte", 32'(tx_data), 32'h43);

    // All three requesters right after reset: requester 0 first, then 1, then 2.
    rst_req = 1'b1; cyc(2); hist.delete();
    for (int r = 0; r < N; r++) push_pkt(r, 2);
    drain("p2_drain", 600);
    check_eq("p2_grants", 32'(hist.size()), 32'd3);
    for (int r = 0; r < N; r++) check_eq("p2_order", 32'(hist[r]), 32'(r));

    // Back-to-back packets from 2 while 0 stays valid: grants must alternate.
    hist.delete();
    for (int j = 0; j < 6; j++) push_pkt(0, 2);
    for (int j = 0; j < 4; j++) push_pkt(2, 2);
    drain("p3_drain", 2000);
    check_eq("p3_grants", 32'(hist.size() >= 8), 32'd1);
    for (int j = 1; j < 8; j++) check_eq("p3_alternate", 32'(hist[j] != hist[j-1]), 32'd1);

    // Requester 1 stalls mid-packet; the timeout hands the line to requester 2.
    uart_len = 3; hist.delete(); t0 = n_tmo;
    push_byte(1, 8'h10, 1'b0); push_stall(1, 40); push_byte(1, 8'h11, 1'b1);
    push_stall(2, 3); push_byte(2, 8'h20, 1'b0); push_byte(2, 8'h21, 1'b1);
    drain("p4_drain", 600);
    check_eq("p4_timeouts", 32'(n_tmo - t0), 32'd1);
    check_eq("p4_first", 32'(hist[0]), 32'd1);
    check_eq("p4_second", 32'(hist[1]), 32'd2);

    // Foreign frame busy at grant entry: byte waits, no timeout.
    hist.delete(); s0 = n_start; t0 = n_tmo; foreign_len = 20; foreign_req = 1'b1;
    push_byte(0, 8'h55, 1'b1);
    drain("p5_drain", 400);
    check_eq("p5_starts", 32'(n_start - s0), 32'd1);
    check_eq("p5_timeouts", 32'(n_tmo - t0), 32'd0);
    check_eq("p5_grant", 32'(hist[0]), 32'd0);

    // Reset while a byte is on the wire.
    uart_len = 10; s0 = n_start;
    push_byte(0, 8'ha1, 1'b0); push_byte(0, 8'ha2, 1'b0); push_byte(0, 8'ha3, 1'b1);
    k = 0;
    while (n_start == s0 && k < 100) begin cyc(1); k++; end
    check_eq("p6_started", 32'(n_start - s0), 32'd1);
    cyc(3);
    rst_req = 1'b1; cyc(2);
    check_eq("p6_gv", 32'(grant_valid), 32'd0);
    check_eq("p6_start", 32'(tx_start), 32'd0);
    check_eq("p6_data", 32'(tx_data), 32'd0);
    check_eq("p6_id", 32'(grant_id), 32'd0);
    s0 = n_start;
    cyc(12);
    check_eq("p6_stray_done", 32'(n_start - s0), 32'd0);
    hist.delete();
    push_pkt(1, 1); push_pkt(0, 1);
    drain("p6_drain", 400);
    check_eq("p6_first_after_rst", 32'(hist[0]), 32'd0);

    // Random traffic with stalls, foreign frames and occasional resets.
    for (int it = 0; it < 80; it++) begin
      push_rand_pkt($urandom_range(0, N - 1));
      if ($urandom_range(0, 2) == 0) push_rand_pkt($urandom_range(0, N - 1));
      uart_len = $urandom_range(1, 8);
      if (!foreign_req && $urandom_range(0, 14) == 0) begin
        foreign_len = $urandom_range(3, 25);
        foreign_req = 1'b1;
      end
      if ($urandom_range(0, 24) == 0) rst_req = 1'b1;
      cyc($urandom_range(1, 25));
    end
    drain("rand_drain", 20000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish, got running, expected done");
    $fatal(1);
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter between several byte-stream requesters: matrix display streamer, operation-result streamer and error/countdown message generator.
- Grants are round-robin at packet granularity. A grant stays locked to one requester until that requester's byte flagged last has finished transmitting.
- A stall timeout reclaims the transmitter from a requester that stops supplying bytes.
- Sits between the ctrl_fsm-driven data sources and uart_tx. This replaces direct tx_start fan-in.

Parameters:
- N_REQ, 3, number of requesters (2..8); index 0 is the error-message source.
- TIMEOUT, 1_000_000, cycles a granted requester may leave req_valid low in LOAD before the grant is revoked (10 ms at 100 MHz).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  reset, synchronous, active-high
- req_valid  in  N_REQ  requester i has a byte on req_data[i]
- req_data  in  8*N_REQ  byte for requester i in bits [8i+7:8i]
- req_last  in  N_REQ  byte from requester i is the final byte of its packet
- req_ready  out  N_REQ  byte from requester i is accepted this cycle (combinational)
- tx_busy  in  1  uart_tx is shifting a frame
- tx_done  in  1  one-cycle pulse from uart_tx at end of a frame's stop bit
- tx_start  out  1  one-cycle pulse: load tx_data and start a frame
- tx_data  out  8  byte to transmit
- grant_valid  out  1  a requester currently holds the transmitter
- grant_id  out  3  index of the current or most recent grant holder
- timeout_flag  out  1  one-cycle pulse when a grant is revoked by timeout

Behaviour:
- Reset (rst high at a clk edge):
  - state=IDLE.
  - tx_start, tx_data, grant_valid, grant_id, timeout_flag, timer and last_flag all 0.
  - RR pointer = N_REQ-1, so requester 0 wins first.
  - A reset mid-frame abandons the packet. uart_tx is not aborted: the current frame completes and its tx_done is ignored because state is IDLE.
- The requester handshake is valid/ready. A byte transfers on a cycle where req_valid[i] and req_ready[i] are both 1. The requester must hold data and last stable while valid and not yet ready.
- req_ready[i] = (state==LOAD) && grant_valid && (grant_id==i) && !tx_busy. All other bits are 0.
- IDLE:
  - If any req_valid bit is set, pick the first set bit searching upward (wrapping) from RR pointer+1.
  - Latch that bit into grant_id, set grant_valid=1, clear timer, go to LOAD. This costs one cycle.
  - Otherwise stay in IDLE.
- LOAD:
  - On accept:
    - register tx_data=req_data[grant]
    - last_flag=req_last[grant]
    - pulse tx_start=1 on the next cycle
    - go to WAIT_DONE.
  - Latency from accept to tx_start is exactly 1 cycle.
  - If req_valid[grant]=0: timer increments. When timer reaches TIMEOUT-1:
    - grant_valid=0
    - timeout_flag pulses for 1 cycle
    - RR pointer=grant_id
    - go to IDLE.
  - If tx_busy=1 in LOAD (a foreign frame is still shifting): wait; the timer does not increment.
- WAIT_DONE:
  - Ignore everything until tx_done.
  - On tx_done with last_flag=1: grant_valid=0, RR pointer=grant_id, go to IDLE.
  - On tx_done with last_flag=0: clear timer, go to LOAD.
  - tx_start is low throughout.
- grant_id keeps its last value while grant_valid=0.
- Fairness: a requester holding a stream of multi-byte packets cannot win two consecutive grants if another requester is pending.
- Simultaneous events:
  - A requester deasserting req_valid at the IDLE arbitration edge is still granted. It then relies on the timeout.
  - tx_done and rst in the same cycle: rst wins.
- Single-byte packets (req_last=1 on the first byte) release the grant right after that byte's tx_done.
- The timer is wide enough for TIMEOUT (ceil(log2(TIMEOUT+1)) bits) and saturates at the compare value. It never wraps.

Test Plan:
- Single requester, packet 0x41,0x42,0x43 (last on 0x43) from req1, tx_done 5 cycles after each tx_start → tx_start pulses 3 times, each exactly 1 cycle after accept, with tx_data 0x41/0x42/0x43; grant_valid=1 from cycle after req_valid to cycle after 3rd tx_done; grant_id=1.
- All three requesters raise valid at the first cycle after reset, each sending 2-byte packets → grant order 0,1,2; no bytes interleave between packets.
- req2 sends packets back-to-back while req0 stays valid → grants alternate 2,0,2,0…; req2 is never granted twice in a row.
- req1 granted, sends one non-last byte 0x10 then drops valid, TIMEOUT=16 → after 16 LOAD cycles timeout_flag pulses once, grant_valid falls, next pending requester is granted.
- tx_busy held high for 20 cycles at grant entry, req0 valid → req_ready[0] stays 0, no tx_start, no timeout; the byte is accepted the cycle after tx_busy falls.
- rst asserted in WAIT_DONE mid-packet → next cycle all outputs 0 and state IDLE; the stray tx_done that follows causes no tx_start; requester 0 is granted first afterwards.
